updown_value_monitor: RTL and testbench
=======================================

Name: updown_value_monitor

Overview:
- Downstream consumer of the 32-bit up/down counter's `value` output; samples it once per clock.
- Checks step legality: every sample must differ from the previous one by exactly +1 or -1, modulo 2^WIDTH.
- Counts wrap-arounds, tracks unsigned min/max, and runs a high/low threshold alarm FSM with hysteresis.
- Raises a sticky interrupt that software clears.

Parameters:
- WIDTH, 32, width of monitored value and thresholds.
- HYST, 4, hysteresis distance for leaving an alarm state.
- WRAP_CW, 8, width of the saturating wrap counter.

Ports:
- clock  input  1  rising-edge clock shared with the counter.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; 0 holds all state.
- value  input  WIDTH  counter output being monitored.
- hi_thresh  input  WIDTH  upper alarm threshold (unsigned), quasi-static.
- lo_thresh  input  WIDTH  lower alarm threshold (unsigned), quasi-static.
- clear  input  1  single-cycle pulse; clears irq, step_err, wrap_count.
- state  output  2  FSM state: 00 NORMAL, 01 HIGH, 10 LOW.
- alarm  output  1  1 when state != NORMAL.
- irq  output  1  sticky interrupt.
- step_err  output  1  sticky illegal-step flag.
- wrap_count  output  WRAP_CW  saturating wrap-event count.
- max_value  output  WIDTH  largest unsigned sample since reset.
- min_value  output  WIDTH  smallest unsigned sample since reset.

Behaviour:

Reset:
- reset=0 asynchronously forces: state=NORMAL, alarm=0, irq=0, step_err=0, wrap_count=0, max_value=0, min_value=all-ones, primed=0, prev=0.
- Reset asserted mid-run discards everything; the first sample after release re-primes.

Timing:
- All outputs are registered. A sample taken at edge k is reflected in the outputs immediately after edge k (1-cycle latency from input to output).

Priming:
- When en=1 and primed=0: prev<=value, primed<=1, min/max updated, FSM evaluated.
- No step or wrap check is made on a priming sample.

Enable:
- en=0: all registers hold, and primed<=0.
- The next en=1 sample re-primes, so a gap in sampling never produces a false step_err.

Step check (en=1, primed=1):
- Legal iff value==prev+1 or value==prev-1, mod 2^WIDTH.
- Anything else, including value==prev, sets step_err. prev<=value always.

Wrap event:
- Counted when (prev==all-ones && value==0) or (prev==0 && value==all-ones).
- wrap_count increments and saturates at 2^WRAP_CW-1; saturation does not wrap.

Min/max:
- Unsigned compares on every en=1 sample, including priming samples.

FSM (evaluated on every en=1 sample, against the current value):
- Any state: value < lo_thresh -> LOW. This check has priority.
- NORMAL: value > hi_thresh -> HIGH; otherwise stay NORMAL.
- HIGH: value <= sat_sub(hi_thresh, HYST) -> NORMAL; otherwise stay HIGH.
- LOW: value >= sat_add(lo_thresh, HYST) -> NORMAL, unless value > hi_thresh, in which case -> HIGH.
- sat_sub floors at 0; sat_add caps at all-ones.
- If lo_thresh >= hi_thresh (misconfiguration), the priority order above still defines behaviour.
- alarm is registered together with state.

irq:
- Set on any of: an entry into HIGH or LOW (from a different state); a 0->1 transition of step_err; a wrap_count increment (including attempts made while saturated).

clear:
- clear=1 zeroes irq, step_err and wrap_count at the edge.
- If a set event occurs in the same cycle, the set wins: flags end at 1, and wrap_count ends at 1 if a wrap occurred that cycle.
- clear does not affect state, min_value or max_value.

Test Plan:
1. Reset/priming: hold reset=0 for 3 cycles, release with en=1 and value=5 -> state=00, irq=0, step_err=0, min=max=5 one cycle later; no step check on the first sample.
2. Legal ramp: value 5,6,7,6,5 -> step_err=0, max=7, min=5. Then inject 9 after 5 -> step_err=1 and irq=1 next cycle. Repeat value 9 after clear -> step_err=1 again.
3. Wrap: value FFFFFFFE, FFFFFFFF, 0, 1, 0, FFFFFFFF -> wrap_count=2, irq=1, step_err=0. With WRAP_CW=2, force 5 wraps -> wrap_count saturates at 3.
4. Hysteresis: hi_thresh=100, lo_thresh=10, HYST=4; ramp 99->101 -> state=HIGH, alarm=1, irq=1. Ramp down: 97 keeps HIGH; 96 -> NORMAL. 9 -> LOW. Climb: 13 keeps LOW; 14 -> NORMAL.
5. Clear vs set collision: pulse clear in the same cycle as a 0->FFFFFFFF wrap -> irq=1 and wrap_count=1 after the edge. Pulse clear alone -> irq=0, step_err=0, wrap_count=0; state and min/max unchanged.
6. Enable gap and async reset: value 20, then en=0 for 3 cycles while value jumps to 50, then en=1 with 50 -> no step_err (re-prime), max=50. Assert reset mid-cycle -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/updown_value_monitor.sv
// Purpose : watches an up/down counter's value; flags illegal steps, counts wraps,
//           tracks min/max and runs a high/low threshold alarm with hysteresis.
// Latency : 1 cycle, every output is registered; no backpressure (en gates sampling).
// Ports   : clock/reset (async active-low), en, value, hi_thresh, lo_thresh, clear ->
//           state, alarm, irq, step_err, wrap_count, max_value, min_value.
module updown_value_monitor #(
  parameter int WIDTH   = 32,
  parameter int HYST    = 4,
  parameter int WRAP_CW = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   value,
  input  logic [WIDTH-1:0]   hi_thresh,
  input  logic [WIDTH-1:0]   lo_thresh,
  input  logic               clear,
  output logic [1:0]         state,
  output logic               alarm,
  output logic               irq,
  output logic               step_err,
  output logic [WRAP_CW-1:0] wrap_count,
  output logic [WIDTH-1:0]   max_value,
  output logic [WIDTH-1:0]   min_value
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    HIGH   = 2'b01,
    LOW    = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0]   ONES     = '1;
  localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0]   HYST_W   = WIDTH'(HYST);
  localparam logic [WRAP_CW-1:0] WRAP_MAX = '1;

  state_t             state_q, state_d;
  logic               alarm_d, irq_d, err_d;
  logic [WRAP_CW-1:0] wrap_d;
  logic [WIDTH-1:0]   max_d, min_d, prev_q, prev_d;
  logic               primed_q, primed_d;

  // Hysteresis exit points, saturating so thresholds near the ends stay sane.
  logic [WIDTH:0]     lo_plus;
  logic [WIDTH-1:0]   lo_exit, hi_exit;

  assign lo_plus = {1'b0, lo_thresh} + {1'b0, HYST_W};
  assign lo_exit = lo_plus[WIDTH] ? ONES : lo_plus[WIDTH-1:0];
  assign hi_exit = (hi_thresh >= HYST_W) ? (hi_thresh - HYST_W) : '0;

  logic step_bad, wrap_ev, entry_ev;
  state_t fsm_next;

  // Threshold FSM next state; the below-low check outranks everything so a
  // misconfigured lo >= hi still has well-defined behaviour.
  always_comb begin
    fsm_next = state_q;
    if (value < lo_thresh) begin
      fsm_next = LOW;
    end else begin
      case (state_q)
        NORMAL:  fsm_next = (value > hi_thresh) ? HIGH : NORMAL;
        HIGH:    fsm_next = (value <= hi_exit) ? NORMAL : HIGH;
        LOW: begin
          if (value >= lo_exit)
            fsm_next = (value > hi_thresh) ? HIGH : NORMAL;
          else
            fsm_next = LOW;
        end
        default: fsm_next = NORMAL;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    primed_d = primed_q;
    prev_d   = prev_q;
    max_d    = max_value;
    min_d    = min_value;
    step_bad = 1'b0;
    wrap_ev  = 1'b0;
    entry_ev = 1'b0;

    // clear acts on the software-visible flags even while sampling is paused,
    // so a clear is never lost; any set event this cycle is OR-ed in after it.
    irq_d  = clear ? 1'b0 : irq;
    err_d  = clear ? 1'b0 : step_err;
    wrap_d = clear ? '0 : wrap_count;

    if (!en) begin
      // A sampling gap forces a re-prime so the jump across it is not judged.
      primed_d = 1'b0;
    end else begin
      if (value > max_value) max_d = value;
      if (value < min_value) min_d = value;

      if (primed_q) begin
        step_bad = (value != prev_q + ONE) && (value != prev_q - ONE);
        wrap_ev  = ((prev_q == ONES) && (value == '0)) ||
                   ((prev_q == '0) && (value == ONES));
      end

      state_d  = fsm_next;
      entry_ev = (fsm_next != state_q) && (fsm_next != NORMAL);
      prev_d   = value;
      primed_d = 1'b1;
    end

    if (step_bad) begin
      // err_d already reflects clear, so a clear plus a bad step counts as a rising flag.
      if (!err_d) irq_d = 1'b1;
      err_d = 1'b1;
    end
    if (wrap_ev) begin
      irq_d = 1'b1;
      if (wrap_d != WRAP_MAX) wrap_d = wrap_d + WRAP_CW'(1);
    end
    if (entry_ev) irq_d = 1'b1;

    alarm_d = (state_d != NORMAL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= NORMAL;
      alarm      <= 1'b0;
      irq        <= 1'b0;
      step_err   <= 1'b0;
      wrap_count <= '0;
      max_value  <= '0;
      min_value  <= ONES;
      primed_q   <= 1'b0;
      prev_q     <= '0;
    end else begin
      state_q    <= state_d;
      alarm      <= alarm_d;
      irq        <= irq_d;
      step_err   <= err_d;
      wrap_count <= wrap_d;
      max_value  <= max_d;
      min_value  <= min_d;
      primed_q   <= primed_d;
      prev_q     <= prev_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_updown_value_monitor.sv
module tb_updown_value_monitor;

  localparam int          W    = 32;
  localparam int          HY   = 4;
  localparam int          CW   = 8;
  localparam longint      MAXV = 64'hFFFF_FFFF;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  value = '0;
  logic [W-1:0]  hi_thresh = 32'd100;
  logic [W-1:0]  lo_thresh = 32'd10;
  logic          clear = 1'b0;
  logic [1:0]    state;
  logic          alarm, irq, step_err;
  logic [CW-1:0] wrap_count;
  logic [W-1:0]  max_value, min_value;

  updown_value_monitor #(.WIDTH(W), .HYST(HY), .WRAP_CW(CW)) dut (
    .clock(clock), .reset(reset), .en(en), .value(value),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .clear(clear),
    .state(state), .alarm(alarm), .irq(irq), .step_err(step_err),
    .wrap_count(wrap_count), .max_value(max_value), .min_value(min_value)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: state 0 normal, 1 high, 2 low.
  int     m_state, m_wc;
  bit     m_irq, m_err, m_primed;
  longint m_max, m_min, m_prev;

  task automatic model_reset();
    m_state = 0; m_wc = 0; m_irq = 0; m_err = 0; m_primed = 0;
    m_max = 0; m_min = MAXV; m_prev = 0;
  endtask

  task automatic model_step(input bit e, input logic [31:0] vin, input bit c,
                            input logic [31:0] hi_in, input logic [31:0] lo_in);
    longint v, hi, lo, d, exit_hi, exit_lo;
    int ns;
    bit set_ev;
    v = longint'(vin); hi = longint'(hi_in); lo = longint'(lo_in);
    set_ev = 0;
    if (c) begin m_irq = 0; m_err = 0; m_wc = 0; end
    if (!e) begin
      m_primed = 0;
    end else begin
      if (v > m_max) m_max = v;
      if (v < m_min) m_min = v;
      if (m_primed) begin
        d = v - m_prev;
        if (d < 0) d = -d;
        if (!(d == 1 || d == MAXV)) begin
          if (!m_err) set_ev = 1;
          m_err = 1;
        end
        if (d == MAXV) begin
          set_ev = 1;
          if (m_wc < (1 << CW) - 1) m_wc++;
        end
      end
      exit_hi = (hi - HY < 0) ? 0 : hi - HY;
      exit_lo = (lo + HY > MAXV) ? MAXV : lo + HY;
      if (v < lo) ns = 2;
      else if (m_state == 0) ns = (v > hi) ? 1 : 0;
      else if (m_state == 1) ns = (v <= exit_hi) ? 0 : 1;
      else ns = (v >= exit_lo) ? ((v > hi) ? 1 : 0) : 2;
      if (ns != m_state && ns != 0) set_ev = 1;
      m_state = ns;
      m_prev = v;
      m_primed = 1;
    end
    if (set_ev) m_irq = 1;
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".state"}, state, m_state);
    chk({pfx, ".alarm"}, alarm, (m_state != 0));
    chk({pfx, ".irq"}, irq, m_irq);
    chk({pfx, ".step_err"}, step_err, m_err);
    chk({pfx, ".wrap_count"}, wrap_count, m_wc);
    chk({pfx, ".max"}, max_value, m_max);
    chk({pfx, ".min"}, min_value, m_min);
  endtask

  // One clock: drive inputs, update model at the edge, compare 1 time unit later.
  task automatic cyc(input bit e, input logic [31:0] v, input bit c);
    en = e; value = v; clear = c;
    @(posedge clock);
    if (!reset) model_reset();
    else model_step(e, v, c, hi_thresh, lo_thresh);
    #1;
    check_all("cyc");
  endtask

  task automatic rand_phase(input int n, input logic [31:0] base,
                            input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] cur;
    int p;
    bit e, c;
    hi_thresh = hi; lo_thresh = lo;
    cur = base;
    for (int i = 0; i < n; i++) begin
      e = ($urandom_range(0, 19) != 0);
      c = ($urandom_range(0, 29) == 0);
      p = $urandom_range(0, 99);
      if (p < 80)      cur = ($urandom_range(0, 1) != 0) ? cur + 32'd1 : cur - 32'd1;
      else if (p < 88) cur = cur;
      else             cur = cur + 32'($urandom_range(0, 40)) - 32'd20;
      cyc(e, cur, c);
    end
  endtask

  initial begin
    model_reset();
    // 1. reset and priming
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 32'd0, 0);
    chk("rst_min", min_value, ONES);
    chk("rst_max", max_value, 0);
    reset = 1'b1;
    cyc(1, 32'd5, 0);
    chk("prime_min", min_value, 5);
    chk("prime_max", max_value, 5);
    chk("prime_err", step_err, 0);

    // 2. legal ramp, illegal jump, repeat after clear
    cyc(1, 32'd6, 0); cyc(1, 32'd7, 0); cyc(1, 32'd6, 0); cyc(1, 32'd5, 0);
    chk("ramp_err", step_err, 0);
    chk("ramp_max", max_value, 7);
    cyc(1, 32'd9, 0);
    chk("jump_err", step_err, 1);
    chk("jump_irq", irq, 1);
    cyc(1, 32'd10, 1);
    chk("clr_err", step_err, 0);
    cyc(1, 32'd10, 0);
    chk("repeat_err", step_err, 1);

    // 3. wraps, then saturation
    hi_thresh = ONES; lo_thresh = 32'd0;
    cyc(0, 32'd0, 1);
    cyc(1, 32'hFFFF_FFFE, 0); cyc(1, ONES, 0); cyc(1, 32'd0, 0);
    cyc(1, 32'd1, 0); cyc(1, 32'd0, 0); cyc(1, ONES, 0);
    chk("wrap_cnt", wrap_count, 2);
    chk("wrap_irq", irq, 1);
    chk("wrap_err", step_err, 0);
    for (int i = 0; i < 300; i++) cyc(1, (i % 2 == 0) ? 32'd0 : ONES, 0);
    chk("wrap_sat", wrap_count, 255);

    // 4. hysteresis
    hi_thresh = 32'd100; lo_thresh = 32'd10;
    cyc(0, 32'd99, 1);
    cyc(1, 32'd99, 0); cyc(1, 32'd100, 0); cyc(1, 32'd101, 0);
    chk("hi_state", state, 1);
    chk("hi_alarm", alarm, 1);
    chk("hi_irq", irq, 1);
    cyc(1, 32'd100, 0); cyc(1, 32'd99, 0); cyc(1, 32'd98, 0); cyc(1, 32'd97, 0);
    chk("hi_hold", state, 1);
    cyc(1, 32'd96, 0);
    chk("hi_exit", state, 0);
    for (int v = 95; v >= 9; v--) cyc(1, 32'(v), 0);
    chk("lo_state", state, 2);
    for (int v = 10; v <= 13; v++) cyc(1, 32'(v), 0);
    chk("lo_hold", state, 2);
    cyc(1, 32'd14, 0);
    chk("lo_exit", state, 0);

    // 5. clear colliding with a wrap, then clear alone
    cyc(0, 32'd0, 0);
    cyc(1, 32'd0, 0);
    cyc(1, ONES, 1);
    chk("coll_irq", irq, 1);
    chk("coll_wc", wrap_count, 1);
    cyc(1, 32'hFFFF_FFFE, 1);
    chk("clr_irq", irq, 0);
    chk("clr_err2", step_err, 0);
    chk("clr_wc", wrap_count, 0);
    chk("clr_state", state, 1);
    chk("clr_min", min_value, 0);
    chk("clr_max", max_value, ONES);

    // 6. enable gap re-prime, then mid-cycle async reset
    reset = 1'b0;
    cyc(0, 32'd0, 0);
    reset = 1'b1;
    cyc(1, 32'd20, 0);
    for (int i = 0; i < 3; i++) cyc(0, 32'd50, 0);
    cyc(1, 32'd50, 0);
    chk("gap_err", step_err, 0);
    chk("gap_max", max_value, 50);
    cyc(1, 32'd60, 0);
    chk("pre_rst_err", step_err, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_alarm", alarm, 0);
    chk("arst_irq", irq, 0);
    chk("arst_err", step_err, 0);
    chk("arst_wc", wrap_count, 0);
    chk("arst_max", max_value, 0);
    chk("arst_min", min_value, ONES);
    model_reset();
    cyc(0, 32'd0, 0);
    reset = 1'b1;

    // Randomized phases against the model
    rand_phase(800, 32'd50, 32'd60, 32'd40);
    rand_phase(800, 32'd3, 32'd20, 32'd8);
    rand_phase(600, 32'd0, 32'd5, ONES - 32'd5);
    rand_phase(600, ONES - 32'd10, ONES - 32'd2, ONES - 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
